// File: rtl/pipe_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_pkg : shared types and constants for the RV32I pipeline controller
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_e;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

endpackage

`default_nettype wire

// File: rtl/hazard_sat_counter.sv
// ----------------------------------------------------------------------------
// hazard_sat_counter : event counter that holds at all-ones instead of wrapping
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hazard_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_I,
  input  logic             reset_I,
  input  logic             inc_I,
  output logic [CNT_W-1:0] count_O
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_I or negedge reset_I) begin
    if (!reset_I) begin
      count_q <= '0;
    end else if (inc_I && (count_q != '1)) begin
      count_q <= count_q + ONE;
    end
  end

  assign count_O = count_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl : stall/flush control, memory-wait watchdog, perf counters
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk_I,
  input  logic             reset_I,
  input  logic [4:0]       idRs1Addr_I,
  input  logic [4:0]       idRs2Addr_I,
  input  logic             idUsesRs1_I,
  input  logic             idUsesRs2_I,
  input  logic [4:0]       exRdAddr_I,
  input  logic             exMemRead_I,
  input  logic             exBranchTaken_I,
  input  logic             memReq_I,
  input  logic             memReady_I,
  output logic             pcEnable_O,
  output logic             ifIdEnable_O,
  output logic             ifIdFlush_O,
  output logic             idExEnable_O,
  output logic             idExFlush_O,
  output logic             exMemEnable_O,
  output logic             memWbEnable_O,
  output logic             halted_O,
  output logic [CNT_W-1:0] stallCycles_O,
  output logic [CNT_W-1:0] flushCount_O
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] waitCnt_q, waitCnt_d;
  logic       memWait;
  logic       loadUse;
  logic       stallInc;
  logic       flushInc;

  assign memWait = memReq_I & ~memReady_I;

  assign loadUse = exMemRead_I & (exRdAddr_I != REG_ZERO) &
                   ((idUsesRs1_I & (idRs1Addr_I == exRdAddr_I)) |
                    (idUsesRs2_I & (idRs2Addr_I == exRdAddr_I)));

  always_ff @(posedge clk_I or negedge reset_I) begin
    if (!reset_I) begin
      state_q   <= RUN;
      waitCnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    waitCnt_d     = waitCnt_q;
    pcEnable_O    = 1'b1;
    ifIdEnable_O  = 1'b1;
    ifIdFlush_O   = 1'b0;
    idExEnable_O  = 1'b1;
    idExFlush_O   = 1'b0;
    exMemEnable_O = 1'b1;
    memWbEnable_O = 1'b1;
    stallInc      = 1'b0;
    flushInc      = 1'b0;

    case (state_q)
      RUN, MEM_WAIT: begin
        if (memWait) begin
          // Whole pipeline holds, so any branch/load-use reappears on release.
          pcEnable_O    = 1'b0;
          ifIdEnable_O  = 1'b0;
          idExEnable_O  = 1'b0;
          exMemEnable_O = 1'b0;
          memWbEnable_O = 1'b0;
          stallInc      = 1'b1;
          if (state_q == RUN) begin
            state_d   = MEM_WAIT;
            waitCnt_d = 8'd1;
          end else if (waitCnt_q == WAIT_LIMIT) begin
            state_d = HALT;
          end else begin
            waitCnt_d = waitCnt_q + 8'd1;
          end
        end else begin
          state_d   = RUN;
          waitCnt_d = 8'd0;
          if (exBranchTaken_I) begin
            ifIdFlush_O = 1'b1;
            idExFlush_O = 1'b1;
            flushInc    = 1'b1;
          end else if (loadUse) begin
            pcEnable_O   = 1'b0;
            ifIdEnable_O = 1'b0;
            idExFlush_O  = 1'b1;
            stallInc     = 1'b1;
          end
        end
      end

      HALT: begin
        pcEnable_O    = 1'b0;
        ifIdEnable_O  = 1'b0;
        idExEnable_O  = 1'b0;
        exMemEnable_O = 1'b0;
        memWbEnable_O = 1'b0;
      end

      default: begin
        pcEnable_O    = 1'b0;
        ifIdEnable_O  = 1'b0;
        idExEnable_O  = 1'b0;
        exMemEnable_O = 1'b0;
        memWbEnable_O = 1'b0;
        state_d       = RUN;
        waitCnt_d     = 8'd0;
      end
    endcase
  end

  assign halted_O = (state_q == HALT);

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_I   (clk_I),
    .reset_I (reset_I),
    .inc_I   (stallInc),
    .count_O (stallCycles_O)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_I   (clk_I),
    .reset_I (reset_I),
    .inc_I   (flushInc),
    .count_O (flushCount_O)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl : directed vector bench for pipeline_hazard_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int CW = 4;

  logic          clk_I = 1'b0;
  logic          reset_I;
  logic [4:0]    idRs1Addr_I, idRs2Addr_I, exRdAddr_I;
  logic          idUsesRs1_I, idUsesRs2_I, exMemRead_I, exBranchTaken_I;
  logic          memReq_I, memReady_I;
  logic          pcEnable_O, ifIdEnable_O, ifIdFlush_O, idExEnable_O;
  logic          idExFlush_O, exMemEnable_O, memWbEnable_O, halted_O;
  logic [CW-1:0] stallCycles_O, flushCount_O;
  logic [6:0]    ctrl;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(CW)) dut (
    .clk_I           (clk_I),
    .reset_I         (reset_I),
    .idRs1Addr_I     (idRs1Addr_I),
    .idRs2Addr_I     (idRs2Addr_I),
    .idUsesRs1_I     (idUsesRs1_I),
    .idUsesRs2_I     (idUsesRs2_I),
    .exRdAddr_I      (exRdAddr_I),
    .exMemRead_I     (exMemRead_I),
    .exBranchTaken_I (exBranchTaken_I),
    .memReq_I        (memReq_I),
    .memReady_I      (memReady_I),
    .pcEnable_O      (pcEnable_O),
    .ifIdEnable_O    (ifIdEnable_O),
    .ifIdFlush_O     (ifIdFlush_O),
    .idExEnable_O    (idExEnable_O),
    .idExFlush_O     (idExFlush_O),
    .exMemEnable_O   (exMemEnable_O),
    .memWbEnable_O   (memWbEnable_O),
    .halted_O        (halted_O),
    .stallCycles_O   (stallCycles_O),
    .flushCount_O    (flushCount_O)
  );

  always #5 clk_I = ~clk_I;

  // {pcEn, ifIdEn, ifIdFlush, idExEn, idExFlush, exMemEn, memWbEn}
  assign ctrl = {pcEnable_O, ifIdEnable_O, ifIdFlush_O, idExEnable_O,
                 idExFlush_O, exMemEnable_O, memWbEnable_O};

  localparam logic [6:0] C_QUIET = 7'b1101011;
  localparam logic [6:0] C_LU    = 7'b0001111;
  localparam logic [6:0] C_BR    = 7'b1111111;
  localparam logic [6:0] C_FRZ   = 7'b0000000;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, ld, br, req, rdy;
    logic [6:0] exp_ctrl;
    int         sinc, finc;
  } vec_t;

  vec_t vt[10];
  int   npass = 0;
  int   ntotal = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;

  function automatic vec_t mk(string n, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic use1, logic use2, logic ld, logic br, logic req,
                              logic rdy, logic [6:0] c, int s, int f);
    vec_t v;
    v.name = n; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.use1 = use1; v.use2 = use2; v.ld = ld; v.br = br; v.req = req; v.rdy = rdy;
    v.exp_ctrl = c; v.sinc = s; v.finc = f;
    return v;
  endfunction

  function automatic int sat(int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd, logic use1,
                       logic use2, logic ld, logic br, logic req, logic rdy);
    idRs1Addr_I = rs1; idRs2Addr_I = rs2; exRdAddr_I = rd;
    idUsesRs1_I = use1; idUsesRs2_I = use2; exMemRead_I = ld;
    exBranchTaken_I = br; memReq_I = req; memReady_I = rdy;
  endtask

  task automatic quiet();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk_I);
    #1;
  endtask

  task automatic check_counts(string tag);
    check({tag, "_stall"}, 32'(stallCycles_O), 32'(sat(exp_stall)));
    check({tag, "_flush"}, 32'(flushCount_O), 32'(sat(exp_flush)));
  endtask

  initial begin
    vt[0] = mk("no_match",   5'd1, 5'd2, 5'd3, 1, 1, 1, 0, 0, 0, C_QUIET, 0, 0);
    vt[1] = mk("lu_rs1",     5'd5, 5'd0, 5'd5, 1, 0, 1, 0, 0, 0, C_LU,    1, 0);
    vt[2] = mk("lu_rd0",     5'd0, 5'd0, 5'd0, 1, 1, 1, 0, 0, 0, C_QUIET, 0, 0);
    vt[3] = mk("lu_rs2",     5'd1, 5'd7, 5'd7, 1, 1, 1, 0, 0, 0, C_LU,    1, 0);
    vt[4] = mk("rs2_unused", 5'd1, 5'd7, 5'd7, 1, 0, 1, 0, 0, 0, C_QUIET, 0, 0);
    vt[5] = mk("rs1_unused", 5'd9, 5'd2, 5'd9, 0, 1, 1, 0, 0, 0, C_QUIET, 0, 0);
    vt[6] = mk("no_load",    5'd5, 5'd0, 5'd5, 1, 0, 0, 0, 0, 0, C_QUIET, 0, 0);
    vt[7] = mk("branch",     5'd1, 5'd2, 5'd3, 1, 1, 0, 1, 0, 0, C_BR,    0, 1);
    vt[8] = mk("branch_lu",  5'd5, 5'd0, 5'd5, 1, 0, 1, 1, 0, 0, C_BR,    0, 1);
    vt[9] = mk("mem_ready",  5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 1, 1, C_QUIET, 0, 0);

    // Reset state
    quiet();
    reset_I = 1'b0;
    #3;
    check("rst_ctrl", 32'(ctrl), 32'(C_QUIET));
    check("rst_halted", 32'(halted_O), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(RUN));
    check_counts("rst");
    @(negedge clk_I);
    reset_I = 1'b1;
    step();

    // Single-cycle hazards from RUN
    foreach (vt[i]) begin
      drive(vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].use1, vt[i].use2,
            vt[i].ld, vt[i].br, vt[i].req, vt[i].rdy);
      #1;
      check({vt[i].name, "_ctrl"}, 32'(ctrl), 32'(vt[i].exp_ctrl));
      exp_stall += vt[i].sinc;
      exp_flush += vt[i].finc;
      step();
      check_counts(vt[i].name);
    end

    // Three-cycle memory wait then ready
    for (int c = 0; c < 3; c++) begin
      drive(5'd5, 5'd0, 5'd5, 1, 0, 1, 0, 1, 0);
      #1;
      check("wait_ctrl", 32'(ctrl), 32'(C_FRZ));
      exp_stall++;
      step();
    end
    check("wait_state", 32'(dut.state_q), 32'(MEM_WAIT));
    check_counts("wait3");
    quiet();
    memReq_I = 1'b1; memReady_I = 1'b1;
    #1;
    check("release_ctrl", 32'(ctrl), 32'(C_QUIET));
    step();
    check("release_state", 32'(dut.state_q), 32'(RUN));
    check_counts("release");

    // Branch held during a two-cycle wait; released by dropping the request
    for (int c = 0; c < 2; c++) begin
      drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 0);
      #1;
      check("wbr_wait_ctrl", 32'(ctrl), 32'(C_FRZ));
      exp_stall++;
      step();
      check_counts("wbr_wait");
    end
    memReq_I = 1'b0;
    #1;
    check("wbr_release_ctrl", 32'(ctrl), 32'(C_BR));
    exp_flush++;
    step();
    check_counts("wbr_release");
    check("wbr_state", 32'(dut.state_q), 32'(RUN));

    // Asynchronous reset in the middle of a wait
    for (int c = 0; c < 5; c++) begin
      drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0);
      step();
    end
    #2;
    reset_I = 1'b0;
    #1;
    check("areset_state", 32'(dut.state_q), 32'(RUN));
    check("areset_wcnt", 32'(dut.waitCnt_q), 32'd0);
    check("areset_halted", 32'(halted_O), 32'd0);
    exp_stall = 0;
    exp_flush = 0;
    check_counts("areset");
    quiet();
    #1;
    check("areset_ctrl", 32'(ctrl), 32'(C_QUIET));
    @(negedge clk_I);
    reset_I = 1'b1;
    step();
    memReq_I = 1'b1; memReady_I = 1'b0;
    step();
    exp_stall++;
    check("restart_wcnt", 32'(dut.waitCnt_q), 32'd1);
    check("restart_state", 32'(dut.state_q), 32'(MEM_WAIT));
    memReady_I = 1'b1;
    step();

    // Watchdog: 16 consecutive waits halt the core; stall count saturates
    memReady_I = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      #1;
      check("wd_halted_pre", 32'(halted_O), 32'd0);
      check("wd_ctrl_pre", 32'(ctrl), 32'(C_FRZ));
      exp_stall++;
      step();
    end
    check("wd_halted", 32'(halted_O), 32'd1);
    check("wd_ctrl", 32'(ctrl), 32'(C_FRZ));
    check_counts("wd_sat");
    drive(5'd5, 5'd0, 5'd5, 1, 0, 1, 1, 1, 1);
    #1;
    check("halt_ctrl", 32'(ctrl), 32'(C_FRZ));
    step();
    step();
    check("halt_sticky", 32'(halted_O), 32'd1);
    check_counts("halt_frozen");
    quiet();
    #2;
    reset_I = 1'b0;
    #1;
    exp_stall = 0;
    exp_flush = 0;
    check("halt_clear", 32'(halted_O), 32'd0);
    check_counts("halt_clear");
    @(negedge clk_I);
    reset_I = 1'b1;
    step();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

`default_nettype wire
